// File: rtl/taho_gate_sched.sv
// Tachometer gate generator and snapshot readout scheduler.
// Define TAHO_SCHED_SKIPZERO_EN to skip channels whose snapshot is zero.
module taho_gate_sched #(
  parameter int CLK_HZ  = 1000000,
  parameter int GATE_HI = 100,
  parameter int NCH     = 4,
  localparam int PW     = $clog2(CLK_HZ),
  localparam int CW     = $clog2(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [16*NCH-1:0] freq_in,
  output logic              sec,
  output logic              rd_valid,
  output logic [CW-1:0]     rd_ch,
  output logic [15:0]       rd_data,
  input  logic              rd_ack,
  output logic              overrun,
  input  logic              clr_ovr
);

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    SCAN
  } state_t;

  state_t            st_q, st_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              run_q, run_d;
  logic              sec_q, sec_d;
  logic              vld_q, vld_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [15:0]       data_q, data_d;
  logic              ovr_q, ovr_d;
  logic [16*NCH-1:0] shadow_q, shadow_d;

  logic              snap_ev;
  logic [CW:0]       first;
  logic [CW:0]       nxt;

`ifdef TAHO_SCHED_SKIPZERO_EN
  // Lowest nonzero channel at or above start; MSB flags a hit.
  function automatic logic [CW:0] find_nz(
    input logic [16*NCH-1:0] v,
    input int                start
  );
    logic [CW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (i >= start && v[16*i +: 16] != 16'd0)
        r = {1'b1, CW'(i)};
    return r;
  endfunction
`endif

  always_comb begin
`ifdef TAHO_SCHED_SKIPZERO_EN
    first = find_nz(freq_in, 0);
    nxt   = find_nz(shadow_q, int'(ptr_q) + 1);
`else
    first = {1'b1, CW'(0)};
    nxt   = {(int'(ptr_q) != NCH - 1), ptr_q + CW'(1)};
`endif
  end

  // run_q holds pcnt at 0 on the first enabled edge.
  always_comb begin
    pcnt_d = '0;
    run_d  = 1'b0;
    sec_d  = 1'b0;
    if (enable) begin
      run_d = 1'b1;
      if (!run_q || pcnt_q == PW'(CLK_HZ - 1))
        pcnt_d = '0;
      else
        pcnt_d = pcnt_q + PW'(1);
      sec_d = (pcnt_d < PW'(GATE_HI));
    end
  end

  assign snap_ev = enable && (pcnt_q == PW'(GATE_HI));

  always_comb begin
    st_d     = st_q;
    ptr_d    = ptr_q;
    vld_d    = vld_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    ovr_d    = ovr_q & ~clr_ovr;
    if (!enable) begin
      st_d  = IDLE;
      vld_d = 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (snap_ev)
            st_d = SNAP;
        end
        SNAP: begin
          shadow_d = freq_in;
          if (first[CW]) begin
            st_d   = SCAN;
            ptr_d  = first[CW-1:0];
            vld_d  = 1'b1;
            data_d = freq_in[16*int'(first[CW-1:0]) +: 16];
          end else begin
            st_d  = IDLE;
            vld_d = 1'b0;
          end
        end
        SCAN: begin
          if (snap_ev) begin
            st_d  = SNAP;
            vld_d = 1'b0;
            if (!(rd_ack && !nxt[CW]))
              ovr_d = 1'b1;
          end else if (rd_ack) begin
            if (nxt[CW]) begin
              ptr_d  = nxt[CW-1:0];
              data_d = shadow_q[16*int'(nxt[CW-1:0]) +: 16];
            end else begin
              st_d  = IDLE;
              vld_d = 1'b0;
            end
          end
        end
        default: begin
          st_d  = IDLE;
          vld_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q     <= IDLE;
      pcnt_q   <= '0;
      run_q    <= 1'b0;
      sec_q    <= 1'b0;
      vld_q    <= 1'b0;
      ptr_q    <= '0;
      data_q   <= '0;
      ovr_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      st_q     <= st_d;
      pcnt_q   <= pcnt_d;
      run_q    <= run_d;
      sec_q    <= sec_d;
      vld_q    <= vld_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      ovr_q    <= ovr_d;
      shadow_q <= shadow_d;
    end
  end

  assign sec      = sec_q;
  assign rd_valid = vld_q;
  assign rd_ch    = ptr_q;
  assign rd_data  = data_q;
  assign overrun  = ovr_q;

endmodule

// File: doc/taho_gate_sched.md
# taho_gate_sched

Gate generator and readout scheduler for a bank of tachometer counters. It produces the periodic `sec` measurement gate that all tachometer counter units share. After each gate it snapshots their 16-bit results and presents them one channel at a time to a single host-side read port with a valid/ack handshake. It sits between the TAHO counter bank and the register or host interface, on the 1 MHz clock domain.

## Interface
- `CLK_HZ`, default 1000000: clock cycles per measurement period; counter width is `$clog2(CLK_HZ)`.
- `GATE_HI`, default 100: cycles per period during which `sec` is high. Must satisfy 1 ≤ GATE_HI ≤ CLK_HZ−3.
- `NCH`, default 4: number of tachometer channels, ≥ 2. `CW` = `$clog2(NCH)`.
- `clock` in 1: system clock (clk_1MHz).
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run gate and scheduler; low holds the block idle.
- `freq_in` in 16·NCH: packed counter results; channel i occupies [16i+15:16i].
- `sec` out 1: measurement gate to all counter units (registered).
- `rd_valid` out 1: `rd_ch`/`rd_data` hold a valid word.
- `rd_ch` out CW: channel index of the presented word.
- `rd_data` out 16: snapshot value of that channel.
- `rd_ack` in 1: host accepts the word; only meaningful while `rd_valid` = 1.
- `overrun` out 1: sticky flag, set when a scan is cut short by the next snapshot.
- `clr_ovr` in 1: synchronous clear of `overrun`.

## Operation
- **Period counter** `pcnt` counts 0..CLK_HZ−1 and then wraps to 0. `sec` is registered high exactly while `pcnt` ∈ [0, GATE_HI−1].
- **Snapshot event** occurs on the cycle where `pcnt` == GATE_HI, the first cycle after `sec` falls. The counter units have already latched their results on the `sec` rising edge.
- **FSM states:** IDLE, SNAP, SCAN.
  - IDLE → SNAP on the snapshot event.
  - SNAP (1 cycle): copy all `freq_in` into shadow registers, set channel pointer to 0, go to SCAN.
  - SCAN: `rd_valid` = 1 and `rd_data` = shadow[ptr].
    - On an edge with `rd_ack` = 1: if ptr = NCH−1, go to IDLE; otherwise increment ptr and stay in SCAN. There is no bubble between words.
    - While `rd_ack` = 0, the word and channel index stay stable.
- **Overrun:** if the snapshot event occurs while in SCAN, set `overrun` and go to SNAP. The remaining old words are dropped and the new scan restarts at channel 0.
- **Overrun clear:** `clr_ovr` clears `overrun`. If set and clear occur on the same edge, set wins.
- **Stable shadow:** changes on `freq_in` outside SNAP never affect `rd_data`.
- **Ignored ack:** `rd_ack` while `rd_valid` = 0 has no effect.
- **`enable` low:** on the next edge, `pcnt` goes to 0, `sec` to 0, FSM to IDLE, `rd_valid` to 0. Shadow registers and `overrun` are retained.
  - When `enable` returns high, `pcnt` starts at 0 and `sec` rises on that first enabled edge.

## Timing
- **Reset values:** `sec` 0, `rd_valid` 0, `rd_ch` 0, `rd_data` 0, `overrun` 0, `pcnt` 0, FSM IDLE, shadows 0.
- **First gate:** `sec` first goes high on the first edge after `reset` deasserts with `enable` = 1.
- **Scan start:** `rd_valid` rises 2 edges after `sec` falls (edge 1: enter SNAP; edge 2: enter SCAN).
- **Full scan time:** NCH cycles minimum when `rd_ack` is tied high.
- **Reset mid-scan:** asserting `reset` mid-scan clears all outputs immediately, without waiting for a clock edge.

## Configuration
- **`TAHO_SCHED_SKIPZERO_EN` defined:** channels whose shadow value is 0 are never presented.
  - The pointer advances past them within the same cycle. SNAP jumps to the first nonzero channel; an ack jumps to the next nonzero channel, or to IDLE if none remain.
  - If all channels are zero, no `rd_valid` is issued that period.
- **Macro undefined:** every channel 0..NCH−1 is presented in order, including zeros.

## Test plan
All scenarios use CLK_HZ=50, GATE_HI=5, NCH=4.

1. **Reset and gate:** hold `reset` low, then release with `enable`=1 → all outputs 0 during reset; afterwards `sec` is high for 5 cycles out of every 50, repeating.
2. **Streaming scan:** `freq_in` = {400,300,200,100} (ch3..ch0), `rd_ack` tied 1 → `rd_valid` is high for 4 consecutive cycles starting 2 cycles after `sec` falls, with `rd_ch` 0..3 and `rd_data` 100, 200, 300, 400.
3. **Backpressure:** `rd_ack` asserted 3 cycles after each `rd_valid` word appears; `freq_in` changed to all 7 after SNAP → each word is held stable until acked; the sequence is still 100, 200, 300, 400; the value 7 appears only in the next period.
4. **Overrun:** `rd_ack`=0 for a whole period → at the next snapshot `overrun`=1 and `rd_ch` returns to 0 with new data. A `clr_ovr` pulse then clears it. A `clr_ovr` pulse coinciding with a new overrun leaves `overrun`=1.
5. **Disable and reset mid-scan:** deassert `enable` mid-scan → `rd_valid`=0 and `sec`=0 on the next edge; re-enabling restarts the gate at `pcnt`=0. Asserting `reset` mid-scan → outputs clear asynchronously.
6. **Skip zero (SKIPZERO_EN):** `freq_in` = {400,0,200,0} → only ch1=200 and ch3=400 are presented. All zeros → no `rd_valid` that period.
